// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Summary  : NUM_CLKS integer-divided clocks derived from refclk, each with a
//            one-cycle rising-edge strobe, reprogrammable at run time through
//            a valid/ready port, plus a lock indication.
// Options  : define CLKDIV_PHASE_EN to add the cfg_phase port; the target
//            counter then starts at (N - P) mod N on a switch, delaying its
//            rising edge by P refclk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
  parameter int NUM_CLKS    = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 10,
  parameter int LOCK_CYCLES = 16,
  localparam int CHAN_W     = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  output logic [NUM_CLKS-1:0] outclk,
  output logic [NUM_CLKS-1:0] outclk_stb,
  output logic                locked
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  // A ratio of 1 cannot produce a high and a low phase, so it runs as 2.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] n);
    return (n == DIV_W'(1)) ? DIV_W'(2) : n;
  endfunction

  localparam logic [DIV_W-1:0] RST_DIV = clamp_div(DIV_W'(DEFAULT_DIV));

  typedef enum logic [1:0] {
    ST_LOCKING = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_UPDATE  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [LOCK_W-1:0]     lock_cnt;
  logic                  sw_done;
  logic [CHAN_W-1:0]     sh_chan;
  logic [DIV_W-1:0]      sh_div;
  logic                  accept;
  logic                  chan_ok;
  logic [NUM_CLKS-1:0]   load;
  logic [DIV_W-1:0]      n_new;
  logic [DIV_W-1:0]      load_cnt;

  assign cfg_ready = (state == ST_LOCKED);
  assign locked    = (state == ST_LOCKED);
  assign accept    = cfg_valid && cfg_ready;
  // Out-of-range channels complete the handshake but change nothing.
  assign chan_ok   = (int'(cfg_chan) < NUM_CLKS);
  assign n_new     = clamp_div(sh_div);

`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0] sh_phase;
  logic [DIV_W-1:0] mod_base;
  logic [DIV_W-1:0] phase_mod;

  // Divisor kept non-zero so a disable request never divides by zero.
  assign mod_base  = (n_new == '0) ? DIV_W'(1) : n_new;
  assign phase_mod = sh_phase % mod_base;
  assign load_cnt  = (n_new - phase_mod) % mod_base;

  // Shadow copy of the accepted request, including the phase offset.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sh_chan  <= '0;
      sh_div   <= DIV_W'(DEFAULT_DIV);
      sh_phase <= '0;
    end else if (accept && chan_ok) begin
      sh_chan  <= cfg_chan;
      sh_div   <= cfg_div;
      sh_phase <= cfg_phase;
    end
  end
`else
  assign load_cnt = '0;

  // Shadow copy of the accepted request.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sh_chan <= '0;
      sh_div  <= DIV_W'(DEFAULT_DIV);
    end else if (accept && chan_ok) begin
      sh_chan <= cfg_chan;
      sh_div  <= cfg_div;
    end
  end
`endif

  // Control state, lock counter and the "target has switched" marker.
  // UPDATE lingers one cycle after the switch so that lock counting starts
  // on the first rising edge at the new ratio.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOCKING;
      lock_cnt <= '0;
      sw_done  <= 1'b0;
    end else begin
      state    <= state_nx;
      lock_cnt <= (state == ST_LOCKING) ? lock_cnt + LOCK_W'(1) : '0;
      sw_done  <= (state == ST_UPDATE) && !sw_done && (|load);
    end
  end

  // Next-state decode for the control FSM.
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOCKING: if (lock_cnt == LOCK_LAST) state_nx = ST_LOCKED;
      ST_LOCKED:  if (accept && chan_ok) state_nx = ST_UPDATE;
      ST_UPDATE:  if (sw_done) state_nx = ST_LOCKING;
      default:    state_nx = ST_LOCKING;
    endcase
  end

  for (genvar c = 0; c < NUM_CLKS; c++) begin : g_chan
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] high;
    logic             at_wrap;
    logic             clk_q;
    logic             stb_q;

    assign high    = div - (div >> 1);
    assign at_wrap = (cnt == div - DIV_W'(1));
    // Switch only at the wrap so no runt pulse escapes; a stopped channel
    // has no wrap and switches straight away.
    assign load[c] = (state == ST_UPDATE) && !sw_done &&
                     (sh_chan == CHAN_W'(c)) && ((div == '0) || at_wrap);

    // Divider counter, active ratio and registered clock/strobe outputs.
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        div   <= RST_DIV;
        clk_q <= 1'b0;
        stb_q <= 1'b0;
      end else begin
        if (div == '0) begin
          clk_q <= 1'b0;
          stb_q <= 1'b0;
        end else begin
          clk_q <= (cnt < high);
          stb_q <= (cnt == '0);
        end
        if (load[c]) begin
          div <= n_new;
          cnt <= (n_new == '0) ? '0 : load_cnt;
        end else if ((div == '0) || at_wrap) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end

    assign outclk[c]     = clk_q;
    assign outclk_stb[c] = stb_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_gen
// Summary  : Scoreboard bench for clk_div_gen. Directed reconfiguration
//            sequence; expected per-cycle outputs come from a table of
//            (channel, start cycle, ratio, first-rise cycle) segments and
//            lock-low windows, queued ahead and checked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_gen;

  localparam int NUM_CLKS    = 5;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 10;
  localparam int LOCK_CYCLES = 16;
  localparam int CHAN_W      = $clog2(NUM_CLKS);

  logic                refclk;
  logic                rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CHAN_W-1:0]   cfg_chan;
  logic [DIV_W-1:0]    cfg_div;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0]    cfg_phase;
`endif
  logic [NUM_CLKS-1:0] outclk;
  logic [NUM_CLKS-1:0] outclk_stb;
  logic                locked;

  clk_div_gen #(
    .NUM_CLKS   (NUM_CLKS),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .outclk    (outclk),
    .outclk_stb(outclk_stb),
    .locked    (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    int                  cyc;
    logic [NUM_CLKS-1:0] clk;
    logic [NUM_CLKS-1:0] stb;
    logic                lk;
  } exp_t;

  typedef struct {
    int ch;
    int from;
    int n;
    int anchor;
  } seg_t;

  typedef struct {
    int lo;
    int hi;
  } span_t;

  exp_t  sb[$];
  seg_t  segs[$];
  span_t lows[$];

  int checks = 0;
  int errors = 0;
  int cyc;

  // Edge count since the last reset release.
  always @(posedge refclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int e, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, e, act, req);
    end
  endtask

  // Expected outputs after edge e: channel c follows its latest segment;
  // a channel with ratio n first rises at 'anchor' and is high ceil(n/2).
  function automatic exp_t model(input int e);
    exp_t x;
    x.cyc = e;
    x.clk = '0;
    x.stb = '0;
    for (int c = 0; c < NUM_CLKS; c++) begin
      int n;
      int a;
      int ph;
      n = DEFAULT_DIV;
      a = 1;
      foreach (segs[i]) begin
        if (segs[i].ch == c && segs[i].from <= e) begin
          n = segs[i].n;
          a = segs[i].anchor;
        end
      end
      if (n > 0) begin
        ph = ((e - a) % n + n) % n;
        x.clk[c] = (ph < n - n / 2);
        x.stb[c] = (ph == 0);
      end
    end
    x.lk = 1'b1;
    foreach (lows[i]) if (e >= lows[i].lo && e <= lows[i].hi) x.lk = 1'b0;
    return x;
  endfunction

  task automatic push_window(input int first, input int last);
    for (int e = first; e <= last; e++) sb.push_back(model(e));
  endtask

  task automatic wait_cyc(input int at);
    int guard;
    guard = 0;
    do begin
      @(negedge refclk);
      guard++;
    end while (cyc < at && guard < 5000);
    if (cyc != at) begin
      checks++;
      errors++;
      $display("FAIL reach_cycle actual=%0d required=%0d", cyc, at);
    end
  endtask

  // Raise a request just after edge 'at'; it should be taken at edge at+1.
  task automatic send(input int at, input int ch, input int dv, input int ph);
    int guard;
    wait_cyc(at);
    cfg_valid = 1'b1;
    cfg_chan  = CHAN_W'(ch);
    cfg_div   = DIV_W'(dv);
`ifdef CLKDIV_PHASE_EN
    cfg_phase = DIV_W'(ph);
`endif
    guard = 0;
    while (cfg_ready !== 1'b1 && guard < 100) begin
      @(negedge refclk);
      guard++;
    end
    @(posedge refclk);
    #1;
    cfg_valid = 1'b0;
    chk("accept_cycle", cyc, 64'(cyc), 64'(at + 1));
    $display("request chan=%0d div=%0d phase=%0d issued after cycle %0d", ch, dv, ph, at);
  endtask

  // Monitor: compare the DUT against the queued expectation for this cycle.
  always @(negedge refclk) begin
    exp_t x;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL skipped_entry cyc=%0d actual=unsampled required=sampled", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        x = sb.pop_front();
        chk("outclk",     cyc, 64'(outclk),     64'(x.clk));
        chk("outclk_stb", cyc, 64'(outclk_stb), 64'(x.stb));
        chk("locked",     cyc, 64'(locked),     64'(x.lk));
        chk("cfg_ready",  cyc, 64'(cfg_ready),  64'(x.lk));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int guard;
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_div   = '0;
`ifdef CLKDIV_PHASE_EN
    cfg_phase = '0;
`endif
    #2 rst = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    chk("rst_outclk",    0, 64'(outclk),     64'(0));
    chk("rst_stb",       0, 64'(outclk_stb), 64'(0));
    chk("rst_locked",    0, 64'(locked),     64'(0));
    chk("rst_cfg_ready", 0, 64'(cfg_ready),  64'(0));
    @(negedge refclk);
    #1 rst = 1'b0;

    // Run 1: ch1 -> N=3 (switch at 50, first rise 51); ch2 -> 0 (switch 90)
    // then 1 (clamped to 2, loads at 112, first rise 113); chan 7 ignored;
    // ch3 request interrupted by reset before its switch at 180.
    segs.push_back('{1,  51, 3,  51});
    segs.push_back('{2,  91, 0,   0});
    segs.push_back('{2, 113, 2, 113});
    lows.push_back('{  1,  15});
    lows.push_back('{ 41,  66});
    lows.push_back('{ 81, 106});
    lows.push_back('{111, 128});
    lows.push_back('{171, 999});
    push_window(1, 175);
    send(40, 1, 3, 0);
    send(80, 2, 0, 0);
    send(110, 2, 1, 0);
    send(140, 7, 5, 0);
    send(170, 3, 4, 0);
    wait_cyc(175);
    #2;
    chk("run1_drained", cyc, 64'(sb.size()), 64'(0));

    rst = 1'b1;
    #1;
    chk("async_outclk",    cyc, 64'(outclk),     64'(0));
    chk("async_stb",       cyc, 64'(outclk_stb), 64'(0));
    chk("async_locked",    cyc, 64'(locked),     64'(0));
    chk("async_cfg_ready", cyc, 64'(cfg_ready),  64'(0));
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    #1 rst = 1'b0;

    // Run 2: everything back at N=10 and aligned; the ch3 request is gone.
    segs.delete();
    lows.delete();
    lows.push_back('{1, 15});
`ifdef CLKDIV_PHASE_EN
    // ch0 P=3 switches at 50 and ch4 P=13 at 90; both then rise three
    // cycles after the untouched N=10 channels.
    segs.push_back('{0, 51, 10, 54});
    segs.push_back('{4, 91, 10, 94});
    lows.push_back('{41, 66});
    lows.push_back('{81, 106});
    push_window(1, 120);
    send(40, 0, 10, 3);
    send(80, 4, 10, 13);
`else
    push_window(1, 40);
`endif
    guard = 0;
    while (sb.size() > 0 && guard < 300) begin
      @(negedge refclk);
      guard++;
    end
    #1;
    chk("run2_drained", cyc, 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
